// File: rtl/fetch_stage.sv
// Fetch stage: PC, zero-bubble j/jal redirect, FD register, flush, buttons.
// Ports: ROM addr/data, branch/jr redirect, stall, FD outputs, sticky PB flags.
module fetch_stage (
  input  logic        clock,
  input  logic        aclr_n,
  input  logic        stallA,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jr_taken,
  input  logic [31:0] jr_target,
  output logic [11:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ins_out,
  output logic [31:0] pc_out,
  output logic [31:0] jump_out,
  output logic        flush_dx,
  input  logic        PB1_raw,
  input  logic        PB2_raw,
  input  logic        pb_clr,
  output logic        PB1_out,
  output logic        PB2_out
);

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] jmp;
  } fd_t;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_inc;
  logic [31:0] jmp_tgt;
  logic        redirect;
  logic        fetch_jump;
  fd_t         fd_q, fd_d;
  logic        flush_q, flush_d;

  logic [1:0]  raw;
  logic [1:0]  sync1_q, sync1_d;
  logic [1:0]  sync2_q, sync2_d;
  logic [1:0]  prev_q, prev_d;
  logic [1:0]  flag_q, flag_d;
  logic [1:0]  fall;

  assign pc_inc   = pc_q + 32'd1;
  assign jmp_tgt  = {5'b0, imem_data[26:0]};
  assign redirect = jr_taken | br_taken;

  always_comb begin
    fetch_jump = 1'b0;
    unique case (imem_data[31:27])
      5'b00001: fetch_jump = 1'b1;
      5'b00011: fetch_jump = 1'b1;
      default:  fetch_jump = 1'b0;
    endcase
  end

  // During reset the PC loads zero, so the ROM is also
  // handed address 0 and word 0 is ready at release.
  always_comb begin
    pc_d = pc_q;
    if (!aclr_n)         pc_d = '0;
    else if (jr_taken)   pc_d = jr_target;
    else if (br_taken)   pc_d = br_target;
    else if (stallA)     pc_d = pc_q;
    else if (fetch_jump) pc_d = jmp_tgt;
    else                 pc_d = pc_inc;
  end

  assign imem_addr = pc_d[11:0];

  always_comb begin
    fd_d    = fd_q;
    flush_d = redirect;
    if (redirect) begin
      fd_d = '0;
    end else if (!stallA) begin
      fd_d.ins = imem_data;
      fd_d.pc  = pc_inc;
      fd_d.jmp = jmp_tgt;
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      pc_q    <= '0;
      fd_q    <= '0;
      flush_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fd_q    <= fd_d;
      flush_q <= flush_d;
    end
  end

  assign ins_out  = fd_q.ins;
  assign pc_out   = fd_q.pc;
  assign jump_out = fd_q.jmp;
  assign flush_dx = flush_q;

  // Buttons are active-low; a press is a 1->0 step seen
  // after the synchronizer, so a held button fires once.
  assign raw  = {PB2_raw, PB1_raw};
  assign fall = prev_q & ~sync2_q;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    flag_d  = flag_q;
    for (int i = 0; i < 2; i++) begin
      if (fall[i])     flag_d[i] = 1'b1;
      else if (pb_clr) flag_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      prev_q  <= 2'b11;
      flag_q  <= 2'b00;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      flag_q  <= flag_d;
    end
  end

  assign PB1_out = flag_q[0];
  assign PB2_out = flag_q[1];

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: ROM model, directed scenarios, random run.
// Checks every output against a transaction-level reference model.
module tb_fetch_stage;

  logic        clock;
  logic        aclr_n;
  logic        stallA;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jr_taken;
  logic [31:0] jr_target;
  logic [11:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ins_out;
  logic [31:0] pc_out;
  logic [31:0] jump_out;
  logic        flush_dx;
  logic        PB1_raw;
  logic        PB2_raw;
  logic        pb_clr;
  logic        PB1_out;
  logic        PB2_out;

  fetch_stage dut (
    .clock     (clock),
    .aclr_n    (aclr_n),
    .stallA    (stallA),
    .br_taken  (br_taken),
    .br_target (br_target),
    .jr_taken  (jr_taken),
    .jr_target (jr_target),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .ins_out   (ins_out),
    .pc_out    (pc_out),
    .jump_out  (jump_out),
    .flush_dx  (flush_dx),
    .PB1_raw   (PB1_raw),
    .PB2_raw   (PB2_raw),
    .pb_clr    (pb_clr),
    .PB1_out   (PB1_out),
    .PB2_out   (PB2_out)
  );

  logic [31:0] rom [4096];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) imem_data <= rom[imem_addr];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_pc, m_ins, m_pco, m_jmp;
  logic        m_flush, m_pb1, m_pb2;
  bit          h1[$];
  bit          h2[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ins = 0; m_pco = 0; m_jmp = 0;
    m_flush = 0; m_pb1 = 0; m_pb2 = 0;
    h1 = '{1, 1, 1, 1};
    h2 = '{1, 1, 1, 1};
  endtask

  // One clock: predict from current inputs, clock, compare.
  task automatic step();
    logic [31:0] d, nxt;
    logic        redir;
    bit          p1, p2;
    #2;
    d     = rom[m_pc[11:0]];
    redir = jr_taken | br_taken;
    if (jr_taken)      nxt = jr_target;
    else if (br_taken) nxt = br_target;
    else if (stallA)   nxt = m_pc;
    else if (d[31:27] == 5'd1 || d[31:27] == 5'd3)
      nxt = {5'b0, d[26:0]};
    else
      nxt = m_pc + 32'd1;
    chk("imem_addr", 32'(imem_addr), {20'b0, nxt[11:0]});
    if (redir) begin
      m_ins = 0; m_pco = 0; m_jmp = 0;
    end else if (!stallA) begin
      m_ins = d; m_pco = m_pc + 32'd1; m_jmp = {5'b0, d[26:0]};
    end
    m_flush = redir;
    m_pc    = nxt;
    // history [0..3] = samples at edges k-3..k
    h1.push_back(PB1_raw); void'(h1.pop_front());
    h2.push_back(PB2_raw); void'(h2.pop_front());
    p1 = (h1[1] == 0) && (h1[0] == 1);
    p2 = (h2[1] == 0) && (h2[0] == 1);
    m_pb1 = p1 ? 1'b1 : (pb_clr ? 1'b0 : m_pb1);
    m_pb2 = p2 ? 1'b1 : (pb_clr ? 1'b0 : m_pb2);
    @(posedge clock);
    #1;
    chk("ins_out", ins_out, m_ins);
    chk("pc_out", pc_out, m_pco);
    chk("jump_out", jump_out, m_jmp);
    chk("flush_dx", 32'(flush_dx), 32'(m_flush));
    chk("PB1_out", 32'(PB1_out), 32'(m_pb1));
    chk("PB2_out", 32'(PB2_out), 32'(m_pb2));
  endtask

  task automatic clr_in();
    stallA = 0; br_taken = 0; jr_taken = 0; pb_clr = 0;
    br_target = 0; jr_target = 0;
  endtask

  task automatic do_reset();
    aclr_n = 0;
    clr_in();
    PB1_raw = 1; PB2_raw = 1;
    #1;
    chk("rst_ins", ins_out, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_jmp", jump_out, 0);
    chk("rst_flush", 32'(flush_dx), 0);
    chk("rst_pb", {30'b0, PB2_out, PB1_out}, 0);
    chk("rst_addr", 32'(imem_addr), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    aclr_n = 1;
    model_reset();
  endtask

  initial begin
    logic [31:0] r;
    aclr_n = 0;
    clr_in();
    PB1_raw = 1; PB2_raw = 1;
    for (int i = 0; i < 4096; i++)
      rom[i] = {5'(16 + i % 16), 27'(i * 13 + 5)};
    rom[2] = {5'b00001, 27'h10};
    do_reset();

    // sequential run and fetch jump
    step();
    chk("seq_ins0", ins_out, rom[0]);
    chk("seq_pc0", pc_out, 32'd1);
    step();
    chk("seq_pc1", pc_out, 32'd2);
    step();
    chk("j_ins", ins_out, rom[2]);
    chk("j_jmp", jump_out, 32'h10);
    step();
    chk("j_tgt_ins", ins_out, rom[16]);
    chk("j_tgt_pc", pc_out, 32'h11);
    step();

    // stall holds FD and PC
    stallA = 1;
    step();
    chk("stall_ins1", ins_out, rom[17]);
    step();
    chk("stall_ins2", ins_out, rom[17]);
    stallA = 0;
    step();
    chk("stall_rel", ins_out, rom[18]);

    // branch with simultaneous stall
    br_taken = 1; br_target = 32'h20; stallA = 1;
    step();
    chk("br_bubble", ins_out, 0);
    chk("br_flush", 32'(flush_dx), 1);
    clr_in();
    step();
    chk("br_ins", ins_out, rom[32]);
    chk("br_noflush", 32'(flush_dx), 0);

    // jr wins over br
    jr_taken = 1; jr_target = 32'h40;
    br_taken = 1; br_target = 32'h20;
    step();
    clr_in();
    step();
    chk("jr_pri", ins_out, rom[64]);

    // back-to-back redirects, then PC wrap
    br_taken = 1; br_target = 32'h80;
    step();
    step();
    chk("b2b_flush", 32'(flush_dx), 1);
    clr_in();
    jr_taken = 1; jr_target = 32'hFFFF_FFFF;
    step();
    clr_in();
    step();
    chk("wrap_pc", pc_out, 0);
    step();

    // button held low for 10 cycles
    PB1_raw = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("pb1_hold", 32'(PB1_out), (i >= 3) ? 32'd1 : 32'd0);
    end
    PB1_raw = 1;
    repeat (3) step();
    pb_clr = 1;
    step();
    pb_clr = 0;
    chk("pb1_clr", 32'(PB1_out), 0);
    PB1_raw = 0;
    step();
    step();
    pb_clr = 1;
    step();
    chk("pb1_setwin", 32'(PB1_out), 1);
    pb_clr = 0;
    PB1_raw = 1;
    step();

    // reset mid-redirect drops pending flush
    br_taken = 1; br_target = 32'h100;
    step();
    aclr_n = 0;
    #1;
    chk("mid_rst_flush", 32'(flush_dx), 0);
    chk("mid_rst_ins", ins_out, 0);

    // random phase with random ROM contents
    for (int i = 0; i < 4096; i++) begin
      r = $urandom;
      if ((r[31:27] == 5'd1 || r[31:27] == 5'd3) &&
          $urandom_range(0, 3) != 0)
        r[31] = 1'b1;
      rom[i] = r;
    end
    do_reset();
    for (int c = 0; c < 600; c++) begin
      stallA    = ($urandom_range(0, 4) == 0);
      br_taken  = ($urandom_range(0, 9) == 0);
      jr_taken  = ($urandom_range(0, 15) == 0);
      br_target = {20'b0, 12'($urandom)};
      jr_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      pb_clr    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) PB1_raw = ~PB1_raw;
      if ($urandom_range(0, 7) == 0) PB2_raw = ~PB2_raw;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock and one reset; the reset SHALL be asynchronous and active-low.
REQ-002 Ports, in this order:
- clock  in  1  sole clock; all state updates on rising edge
- aclr_n  in  1  asynchronous active-low clear
- stallA  in  1  hazard stall; holds PC and the FD register
- br_taken  in  1  branch resolved taken in execute
- br_target  in  32  branch target
- jr_taken  in  1  jr resolved in execute
- jr_target  in  32  jr target (rs value)
- imem_addr  out  12  address to the synchronous instruction ROM, which registers it on the same edge as PC
- imem_data  in  32  ROM word for the current PC
- ins_out  out  32  FD instruction to decode
- pc_out  out  32  FD PC+1 to decode
- jump_out  out  32  FD jump target {5'b0, ins[26:0]}
- flush_dx  out  1  one-cycle clear pulse to decode DX registers
- PB1_raw, PB2_raw  in  1  raw push buttons, active-low, asynchronous
- pb_clr  in  1  clears both sticky button flags
- PB1_out, PB2_out  out  1  sticky press flags to decode

Function
REQ-003 The PC register SHALL be 32 bits; imem_addr SHALL be pc_next[11:0], where pc_next is the value the PC loads at the next edge, so imem_data always corresponds to the PC.
REQ-004 pc_next priority, highest first: jr_taken -> jr_target; br_taken -> br_target; stallA -> PC; fetch jump -> {5'b0, imem_data[26:0]}; otherwise PC+1.
REQ-005 A fetch jump SHALL be imem_data[31:27] = 5'b00001 (j) or 5'b00011 (jal); it SHALL redirect with zero bubbles.
REQ-006 PC+1 SHALL wrap modulo 2^32 without any flag.
REQ-007 The FD register (ins_out, pc_out, jump_out) SHALL load {imem_data, PC+1, {5'b0, imem_data[26:0]}} on each edge when stallA=0 and there is no redirect.
REQ-008 On an edge with stallA=1 and no redirect, the FD register SHALL hold its value.
REQ-009 On an edge with jr_taken or br_taken, the FD register SHALL load all zeros (NOP bubble), regardless of stallA.
REQ-010 flush_dx SHALL be a registered signal that is 1 for exactly the cycle following any edge at which jr_taken or br_taken was 1, and 0 otherwise.
REQ-011 A redirect on consecutive cycles SHALL produce a flush pulse on each following cycle.
REQ-012 Each PBx_raw SHALL pass through a two-flop synchronizer followed by a falling-edge detector.
REQ-013 A detected press SHALL set PBx_out on the next edge; PBx_out SHALL stay 1 until pb_clr.
REQ-014 If pb_clr and a press occur on the same edge, the flag SHALL be 1 after that edge (set wins).
REQ-015 A button held low SHALL set its flag only once per press.

Reset
REQ-016 While aclr_n=0, the block SHALL hold PC=0, ins_out=0, pc_out=0, jump_out=0, flush_dx=0, PB1_out=PB2_out=0, and all synchronizer and edge flops at 1 (released state).
REQ-017 imem_addr SHALL follow pc_next combinationally during reset.
REQ-018 After aclr_n deasserts, the first fetch SHALL be address 0.
REQ-019 Reset asserted mid-redirect or mid-stall SHALL override everything and drop any pending flush pulse.

Verification
REQ-020 Sequential run: ROM words 0..3 are non-jump and there is no stall -> ins_out shows words 0,1,2,3 on consecutive cycles, with pc_out=1,2,3,4.
REQ-021 Fetch jump: word 2 = j 0x10 -> fetch order 0,1,2,0x10,0x11 with no bubble; jump_out=0x10 when ins_out=word 2.
REQ-022 Stall: stallA=1 for 2 cycles while ins_out=word 3 -> ins_out and PC held for 2 cycles, then word 4 follows.
REQ-023 Branch: br_taken=1 with br_target=0x20 and stallA=1 in the same cycle -> next cycle ins_out=0 and flush_dx=1, then ins_out=word 0x20 with flush_dx=0.
REQ-024 Both redirects: jr_taken=1 (jr_target=0x40) and br_taken=1 (br_target=0x20) together -> next fetch address 0x40.
REQ-025 Buttons: PB1_raw held low 10 cycles -> PB1_out=1 three edges after the fall and remains 1; pb_clr pulse -> 0; a new press coinciding with pb_clr -> 1.
